// File: rtl/mem_pkg.sv
// Shared memory-map definitions: bank codes, bus widths and the sequencer
// state encoding. Also used by the memory_bus decode logic.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [1:0] BANK_RAM    = 2'b00;
    localparam logic [1:0] BANK_ROM    = 2'b01;
    localparam logic [1:0] BANK_PERIPH = 2'b10;
    localparam logic [1:0] BANK_BRAM   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        WAIT   = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    // Select the wait-cycle count that belongs to a bank
    function automatic logic [2:0] bank_wait(
        input logic [1:0] bank,
        input logic [2:0] w_ram,
        input logic [2:0] w_rom,
        input logic [2:0] w_periph,
        input logic [2:0] w_bram
    );
        logic [2:0] w;
        case (bank)
            BANK_RAM:    w = w_ram;
            BANK_ROM:    w = w_rom;
            BANK_PERIPH: w = w_periph;
            BANK_BRAM:   w = w_bram;
            default:     w = w_ram;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// CPU-side request/response signals and memory-bus signals of the access
// sequencer. The sequencer uses the master view; the CPU/bus environment
// uses the slave view.
interface mem_access_sequencer_if;
    import mem_pkg::*;

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_busy;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_data_in;
    logic [DATA_W-1:0] bus_data_out;
    logic              bus_enable;
    logic              bus_write_enable;

    modport master (
        input  cpu_req, cpu_write, cpu_address, cpu_wdata, bus_data_out,
        output cpu_rdata, cpu_ready, cpu_busy,
               bus_address, bus_data_in, bus_enable, bus_write_enable
    );

    modport slave (
        output cpu_req, cpu_write, cpu_address, cpu_wdata, bus_data_out,
        input  cpu_rdata, cpu_ready, cpu_busy,
               bus_address, bus_data_in, bus_enable, bus_write_enable
    );

endinterface

// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: turns a level CPU request into a
// SETUP / WAIT(N) / ACCESS / DONE bus cycle, with N chosen per address bank.
// Every output is a flop, updated together with the state register, so
// each output already reflects the state it belongs to.
module mem_access_sequencer
    import mem_pkg::*;
#(
    parameter logic [2:0] WAIT_RAM    = 3'd1,
    parameter logic [2:0] WAIT_ROM    = 3'd0,
    parameter logic [2:0] WAIT_PERIPH = 3'd2,
    parameter logic [2:0] WAIT_BRAM   = 3'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_sequencer_if.master mif
);

    seq_state_e        state_r;
    logic [2:0]        wait_cnt_r;
    logic              write_r;
    logic [ADDR_W-1:0] bus_address_r;
    logic [DATA_W-1:0] bus_data_in_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              bus_enable_r;
    logic              bus_we_r;
    logic              cpu_ready_r;
    logic              cpu_busy_r;

    // State transitions, wait counting, request latching and output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            wait_cnt_r    <= 3'd0;
            write_r       <= 1'b0;
            bus_address_r <= 16'h0000;
            bus_data_in_r <= 16'h0000;
            cpu_rdata_r   <= 16'h0000;
            bus_enable_r  <= 1'b0;
            bus_we_r      <= 1'b0;
            cpu_ready_r   <= 1'b0;
            cpu_busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (mif.cpu_req) begin
                        state_r       <= SETUP;
                        write_r       <= mif.cpu_write;
                        // Bit 15 is a CPU-side alias; the bus only sees 15 bits
                        bus_address_r <= {1'b0, mif.cpu_address[14:0]};
                        bus_data_in_r <= mif.cpu_wdata;
                        wait_cnt_r    <= bank_wait(mif.cpu_address[14:13],
                                                   WAIT_RAM, WAIT_ROM,
                                                   WAIT_PERIPH, WAIT_BRAM);
                        bus_enable_r  <= 1'b1;
                        bus_we_r      <= 1'b0;
                        cpu_ready_r   <= 1'b0;
                        cpu_busy_r    <= 1'b1;
                    end else begin
                        state_r       <= IDLE;
                        bus_enable_r  <= 1'b0;
                        bus_we_r      <= 1'b0;
                        cpu_ready_r   <= 1'b0;
                        cpu_busy_r    <= 1'b0;
                    end
                end
                SETUP: begin
                    bus_enable_r <= 1'b1;
                    cpu_busy_r   <= 1'b1;
                    cpu_ready_r  <= 1'b0;
                    if (wait_cnt_r == 3'd0) begin
                        state_r  <= ACCESS;
                        bus_we_r <= write_r;
                    end else begin
                        state_r  <= WAIT;
                        bus_we_r <= 1'b0;
                    end
                end
                WAIT: begin
                    bus_enable_r <= 1'b1;
                    cpu_busy_r   <= 1'b1;
                    cpu_ready_r  <= 1'b0;
                    // Counter enters WAIT at N, so N cycles are spent here
                    if (wait_cnt_r <= 3'd1) begin
                        wait_cnt_r <= 3'd0;
                        state_r    <= ACCESS;
                        bus_we_r   <= write_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                        state_r    <= WAIT;
                        bus_we_r   <= 1'b0;
                    end
                end
                ACCESS: begin
                    state_r      <= DONE;
                    bus_enable_r <= 1'b0;
                    bus_we_r     <= 1'b0;
                    cpu_busy_r   <= 1'b0;
                    cpu_ready_r  <= 1'b1;
                    if (!write_r) begin
                        cpu_rdata_r <= mif.bus_data_out;
                    end else begin
                        cpu_rdata_r <= cpu_rdata_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    wait_cnt_r   <= 3'd0;
                    bus_enable_r <= 1'b0;
                    bus_we_r     <= 1'b0;
                    cpu_ready_r  <= 1'b0;
                    cpu_busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign mif.cpu_rdata        = cpu_rdata_r;
    assign mif.cpu_ready        = cpu_ready_r;
    assign mif.cpu_busy         = cpu_busy_r;
    assign mif.bus_address      = bus_address_r;
    assign mif.bus_data_in      = bus_data_in_r;
    assign mif.bus_enable       = bus_enable_r;
    assign mif.bus_write_enable = bus_we_r;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with default wait parameters
// (RAM 1, ROM 0, PERIPH 2, BRAM 1). Cycle 0 is the cycle whose closing edge
// accepts the request, so DONE/cpu_ready is expected in cycle 3+N.
module tb_mem_access_sequencer;

    logic clk;
    logic reset;
    logic use_addr_data;
    logic [15:0] fixed_data;
    int n_checks;
    int n_pass;

    mem_access_sequencer_if mif();

    mem_access_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    // Memory model: either a fixed read word or one derived from the address
    assign mif.bus_data_out = use_addr_data ? {8'h5A, mif.bus_address[7:0]} : fixed_data;

    initial clk = 1'b0;
    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access and follow it to its cpu_ready pulse
    task automatic run_access(input string tag, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input int n_wait,
                              input logic [15:0] exp_baddr);
        int lat;
        int we_cnt;
        logic seen;
        logic [15:0] we_addr;
        logic [15:0] we_data;
        mif.cpu_req = 1'b1;
        mif.cpu_write = wr;
        mif.cpu_address = addr;
        mif.cpu_wdata = wd;
        tick();
        check_val({tag, "_busy"}, 16'(mif.cpu_busy), 16'h0001);
        check_val({tag, "_baddr"}, mif.bus_address, exp_baddr);
        // Disturb the CPU inputs while busy; they must be ignored
        mif.cpu_req = 1'b0;
        mif.cpu_write = ~wr;
        mif.cpu_address = 16'hFFFF;
        mif.cpu_wdata = ~wd;
        lat = 1;
        we_cnt = 0;
        seen = 1'b0;
        we_addr = 16'h0000;
        we_data = 16'h0000;
        while (!seen && lat < 20) begin
            if (mif.bus_write_enable) begin
                we_cnt++;
                we_addr = mif.bus_address;
                we_data = mif.bus_data_in;
            end
            if (mif.cpu_ready) begin
                seen = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        check_val({tag, "_latency"}, 16'(lat), 16'(3 + n_wait));
        check_val({tag, "_we_cycles"}, 16'(we_cnt), wr ? 16'h0001 : 16'h0000);
        if (wr) begin
            check_val({tag, "_we_addr"}, we_addr, exp_baddr);
            check_val({tag, "_we_data"}, we_data, wd);
        end
        check_val({tag, "_done_en"}, 16'(mif.bus_enable), 16'h0000);
        tick();
        check_val({tag, "_ready_pulse"}, 16'(mif.cpu_ready), 16'h0000);
        check_val({tag, "_idle_busy"}, 16'(mif.cpu_busy), 16'h0000);
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        use_addr_data = 1'b0;
        fixed_data = 16'h0000;
        reset = 1'b0;
        mif.cpu_req = 1'b0;
        mif.cpu_write = 1'b0;
        mif.cpu_address = 16'h0000;
        mif.cpu_wdata = 16'h0000;
        tick();
        tick();
        check_val("rst_rdata", mif.cpu_rdata, 16'h0000);
        check_val("rst_ready", 16'(mif.cpu_ready), 16'h0000);
        check_val("rst_busy", 16'(mif.cpu_busy), 16'h0000);
        check_val("rst_en", 16'(mif.bus_enable), 16'h0000);
        check_val("rst_we", 16'(mif.bus_write_enable), 16'h0000);
        check_val("rst_baddr", mif.bus_address, 16'h0000);
        reset = 1'b1;

        // ROM read, no wait states, accepted on the first edge after reset
        fixed_data = 16'hBEEF;
        run_access("rom_rd", 1'b0, 16'h2005, 16'h0000, 0, 16'h2005);
        check_val("rom_rd_rdata", mif.cpu_rdata, 16'hBEEF);

        // RAM write, one wait state
        fixed_data = 16'h1111;
        run_access("ram_wr", 1'b1, 16'h0010, 16'h1234, 1, 16'h0010);
        check_val("ram_wr_rdata", mif.cpu_rdata, 16'hBEEF);

        // Peripheral write, two wait states
        run_access("per_wr", 1'b1, 16'h4002, 16'h00FF, 2, 16'h4002);
        check_val("per_wr_rdata", mif.cpu_rdata, 16'hBEEF);

        // Back-to-back BRAM reads with cpu_req held high
        use_addr_data = 1'b1;
        mif.cpu_req = 1'b1;
        mif.cpu_write = 1'b0;
        mif.cpu_address = 16'h6001;
        tick();
        mif.cpu_address = 16'h6002;
        check_val("b2b_setup1_en", 16'(mif.bus_enable), 16'h0001);
        tick();
        check_val("b2b_wait1_ready", 16'(mif.cpu_ready), 16'h0000);
        tick();
        check_val("b2b_access1_baddr", mif.bus_address, 16'h6001);
        tick();
        check_val("b2b_done1_ready", 16'(mif.cpu_ready), 16'h0001);
        check_val("b2b_done1_rdata", mif.cpu_rdata, 16'h5A01);
        tick();
        mif.cpu_req = 1'b0;
        check_val("b2b_setup2_ready", 16'(mif.cpu_ready), 16'h0000);
        check_val("b2b_setup2_busy", 16'(mif.cpu_busy), 16'h0001);
        check_val("b2b_setup2_baddr", mif.bus_address, 16'h6002);
        tick();
        tick();
        tick();
        check_val("b2b_done2_ready", 16'(mif.cpu_ready), 16'h0001);
        check_val("b2b_done2_rdata", mif.cpu_rdata, 16'h5A02);
        tick();
        check_val("b2b_idle_ready", 16'(mif.cpu_ready), 16'h0000);
        use_addr_data = 1'b0;

        // Reset while a RAM write sits in WAIT
        mif.cpu_req = 1'b1;
        mif.cpu_write = 1'b1;
        mif.cpu_address = 16'h0020;
        mif.cpu_wdata = 16'hCAFE;
        tick();
        mif.cpu_req = 1'b0;
        tick();
        check_val("rstw_wait_en", 16'(mif.bus_enable), 16'h0001);
        check_val("rstw_wait_we", 16'(mif.bus_write_enable), 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        check_val("rstw_en", 16'(mif.bus_enable), 16'h0000);
        check_val("rstw_we", 16'(mif.bus_write_enable), 16'h0000);
        check_val("rstw_busy", 16'(mif.cpu_busy), 16'h0000);
        check_val("rstw_rdata", mif.cpu_rdata, 16'h0000);
        check_val("rstw_baddr", mif.bus_address, 16'h0000);
        tick();
        check_val("rstw_held_we", 16'(mif.bus_write_enable), 16'h0000);
        reset = 1'b1;
        fixed_data = 16'h1357;
        run_access("rstw_rd", 1'b0, 16'h0020, 16'h0000, 1, 16'h0020);
        check_val("rstw_rd_rdata", mif.cpu_rdata, 16'h1357);

        // Address bit 15 is dropped; bank comes from bits 14:13 (RAM)
        fixed_data = 16'h2468;
        run_access("hi_rd", 1'b0, 16'h8003, 16'h0000, 1, 16'h0003);
        check_val("hi_rd_rdata", mif.cpu_rdata, 16'h2468);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter WAIT_RAM, default 1, wait cycles for bank 2'b00 (RAM), range 0..7.
REQ-002 SHALL have parameter WAIT_ROM, default 0, wait cycles for bank 2'b01 (ROM), range 0..7.
REQ-003 SHALL have parameter WAIT_PERIPH, default 2, wait cycles for bank 2'b10 (peripherals), range 0..7.
REQ-004 SHALL have parameter WAIT_BRAM, default 1, wait cycles for bank 2'b11 (block RAM), range 0..7.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port cpu_req  input  1  CPU access request, level-sensitive.
REQ-008 SHALL have port cpu_write  input  1  1 = write, 0 = read, sampled with cpu_req.
REQ-009 SHALL have port cpu_address  input  16  CPU word address.
REQ-010 SHALL have port cpu_wdata  input  16  CPU write data.
REQ-011 SHALL have port cpu_rdata  output  16  last completed read data.
REQ-012 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port cpu_busy  output  1  access in progress; new requests are not accepted.
REQ-014 SHALL have port bus_address  output  16  address to memory bus.
REQ-015 SHALL have port bus_data_in  output  16  write data to memory bus.
REQ-016 SHALL have port bus_data_out  input  16  read data from memory bus.
REQ-017 SHALL have port bus_enable  output  1  memory bus access enable.
REQ-018 SHALL have port bus_write_enable  output  1  memory bus write strobe.

Function
REQ-019 SHALL implement states IDLE, SETUP, WAIT, ACCESS, DONE.
REQ-020 SHALL accept a request in IDLE or DONE when cpu_req=1: latch cpu_write, cpu_address, cpu_wdata, and bank = cpu_address[14:13]; next state SETUP.
REQ-021 SHALL, on that acceptance, load the wait counter with the WAIT_* value for the latched bank.
REQ-022 SHALL, in SETUP, go to ACCESS if the counter is 0, else to WAIT; in WAIT, decrement the counter each cycle and go to ACCESS when it reaches 0.
REQ-023 SHALL last exactly 1 cycle in each of SETUP and ACCESS, and exactly N cycles in WAIT, where N = the bank's WAIT_* value.
REQ-024 SHALL go from ACCESS to DONE; from DONE, go to SETUP if cpu_req=1, else to IDLE.
REQ-025 SHALL drive bus_address = {1'b0, latched address[14:0]} and bus_data_in = latched wdata, stable from SETUP through ACCESS.
REQ-026 SHALL assert bus_enable in SETUP, WAIT and ACCESS only.
REQ-027 SHALL assert bus_write_enable for exactly the single ACCESS cycle of a write, and never during a read.
REQ-028 SHALL, on a read, capture bus_data_out into cpu_rdata at the clock edge that leaves ACCESS.
REQ-029 SHALL hold cpu_rdata until the next read completes; writes SHALL NOT change cpu_rdata.
REQ-030 SHALL assert cpu_ready in DONE only, for exactly 1 cycle per access.
REQ-031 SHALL give latency from the accepting edge to cpu_ready high of 3+N cycles.
REQ-032 SHALL drive cpu_busy=1 in SETUP, WAIT and ACCESS, and 0 in IDLE and DONE.
REQ-033 SHALL ignore cpu_req and changes to cpu_* inputs while cpu_busy=1.
REQ-034 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-035 SHALL, while reset=0, immediately force: state IDLE, counter 0, cpu_rdata 0x0000, and all other outputs 0.
REQ-036 SHALL abort any in-flight access on reset; bus_write_enable SHALL drop asynchronously even mid-ACCESS.
REQ-037 SHALL accept the first request on the first rising edge after reset returns to 1.

Structure
REQ-038 SHALL take the following from shared package mem_pkg, reused by memory_bus decode: bank constants BANK_RAM=2'b00, BANK_ROM=2'b01, BANK_PERIPH=2'b10, BANK_BRAM=2'b11, and the state encoding.
REQ-039 SHALL have no sub-module; the wait counter is inline, and the block instantiates directly upstream of memory_bus.

Verification
REQ-040 ROM read: addr 0x2005, bus_data_out=0xBEEF, WAIT_ROM=0 -> cpu_ready at accept+3, cpu_rdata=0xBEEF, bus_write_enable never 1.
REQ-041 RAM write: addr 0x0010, data 0x1234, WAIT_RAM=1 -> bus_write_enable high 1 cycle with bus_address=0x0010 and bus_data_in=0x1234, cpu_ready at accept+4.
REQ-042 Peripheral write: addr 0x4002, data 0x00FF, WAIT_PERIPH=2 -> cpu_ready at accept+5, cpu_rdata unchanged.
REQ-043 Back-to-back: cpu_req held 1, reads at 0x6001 then 0x6002 -> second SETUP directly after first DONE, two separate 1-cycle cpu_ready pulses.
REQ-044 Reset during WAIT of a write to 0x0020 -> bus_write_enable never asserted, outputs 0 immediately; after release, a read of 0x0020 completes normally.
REQ-045 Address 0x8003 read -> bus_address=0x0003, bank RAM timing (accept+4).
